// File: rtl/hdmi_qsys_sysid_pkg.sv
// ---------------------------------------------------------------------------
// hdmi_qsys_sysid_pkg
// Shared definitions for the sysid checker: FSM state encoding, the sysid
// word addresses and the default identity values of the HDMI Qsys system.
// ---------------------------------------------------------------------------
package hdmi_qsys_sysid_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_ID  = 2'd1,
        RD_TS  = 2'd2,
        FINISH = 2'd3
    } state_t;

    // Word addresses inside the sysid slave
    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

    // Identity of the system this checker was generated against
    localparam logic [31:0] DEFAULT_EXPECTED_ID = 32'd0;
    localparam logic [31:0] DEFAULT_EXPECTED_TS = 32'd1539604058;

    // Width of the stall counter; covers TIMEOUT_CYCLES up to 65535
    localparam int TMO_W = 16;

endpackage

// File: rtl/hdmi_qsys_sysid_timeout.sv
// ---------------------------------------------------------------------------
// hdmi_qsys_sysid_timeout
// Counts stall cycles of one Avalon read and flags when the stall that is
// currently in progress would bring the count up to the limit.
//
// Ports:
//   clock    in   rising-edge clock
//   reset_n  in   synchronous active-low reset
//   clear    in   zero the counter (no read in flight / read accepted)
//   enable   in   one stall cycle is happening this cycle
//   limit    in   number of stall cycles allowed per read (>= 1)
//   expired  out  this stall cycle is the limit-th one; give up the read
// ---------------------------------------------------------------------------
module hdmi_qsys_sysid_timeout
    import hdmi_qsys_sysid_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [TMO_W-1:0] limit,
    output logic             expired
);

    logic [TMO_W-1:0] count;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

    // Widened compare so a limit of 65535 cannot wrap the increment
    assign expired = enable &&
                     (({1'b0, count} + {{TMO_W{1'b0}}, 1'b1}) >= {1'b0, limit});

endmodule

// File: rtl/hdmi_qsys_sysid_checker.sv
// ---------------------------------------------------------------------------
// hdmi_qsys_sysid_checker
// Avalon-MM master that reads the sysid slave (word 0 = system id, word 1 =
// generation timestamp), compares both against the expected values and
// reports the outcome. Reads use latency 0: data is taken in the cycle
// waitrequest is low. Each read gives up after TIMEOUT_CYCLES stall cycles.
//
// Parameters:
//   EXPECTED_ID     value required at word 0
//   EXPECTED_TS     value required at word 1
//   TIMEOUT_CYCLES  stall cycles allowed per read (1..65535)
//
// Ports:
//   clock, reset_n        clock, synchronous active-low reset
//   start                 one-cycle pulse launching a check (ignored when busy)
//   address, read         Avalon master request
//   waitrequest, readdata Avalon slave response
//   busy                  check in progress (RD_ID, RD_TS, FINISH)
//   done                  one-cycle pulse at end of check
//   id_ok, ts_ok          comparison results, held until next start
//   timeout               a read was abandoned
//   id_value, ts_value    last words captured from the slave
//
// Build option: define SYSID_CHECKER_AUTOSTART_EN to run one check
// automatically in the first cycle after reset is released.
// ---------------------------------------------------------------------------
module hdmi_qsys_sysid_checker
    import hdmi_qsys_sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = DEFAULT_EXPECTED_ID,
    parameter logic [31:0] EXPECTED_TS    = DEFAULT_EXPECTED_TS,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        address,
    output logic        read,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

    state_t state;
    logic   start_int;
    logic   accept;
    logic   tmo_clear;
    logic   tmo_en;
    logic   tmo_expired;

`ifdef SYSID_CHECKER_AUTOSTART_EN
    // Armed during reset, consumed by the first clock edge after release
    logic auto_pend;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            auto_pend <= 1'b1;
        end else begin
            auto_pend <= 1'b0;
        end
    end

    assign start_int = start | auto_pend;
`else
    assign start_int = start;
`endif

    // read is registered and only high in the read states, so it doubles
    // as "a transfer is being requested this cycle"
    assign accept    = read && !waitrequest;
    assign tmo_en    = read && waitrequest;
    // Zeroing on accept makes the RD_TS read start from a fresh count
    assign tmo_clear = !read || accept;

    hdmi_qsys_sysid_timeout u_timeout (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (tmo_clear),
        .enable  (tmo_en),
        .limit   (TMO_LIMIT),
        .expired (tmo_expired)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= IDLE;
            address  <= ADDR_ID;
            read     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            id_ok    <= 1'b0;
            ts_ok    <= 1'b0;
            timeout  <= 1'b0;
            id_value <= '0;
            ts_value <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_int) begin
                        state   <= RD_ID;
                        busy    <= 1'b1;
                        read    <= 1'b1;
                        address <= ADDR_ID;
                        id_ok   <= 1'b0;
                        ts_ok   <= 1'b0;
                        timeout <= 1'b0;
                    end
                end

                RD_ID: begin
                    // An accept in the expiring cycle still wins
                    if (!waitrequest) begin
                        id_value <= readdata;
                        id_ok    <= (readdata == EXPECTED_ID);
                        address  <= ADDR_TS;
                        state    <= RD_TS;
                    end else if (tmo_expired) begin
                        read    <= 1'b0;
                        timeout <= 1'b1;
                        done    <= 1'b1;
                        state   <= FINISH;
                    end
                end

                RD_TS: begin
                    if (!waitrequest) begin
                        ts_value <= readdata;
                        ts_ok    <= (readdata == EXPECTED_TS);
                        read     <= 1'b0;
                        address  <= ADDR_ID;
                        done     <= 1'b1;
                        state    <= FINISH;
                    end else if (tmo_expired) begin
                        read    <= 1'b0;
                        address <= ADDR_ID;
                        timeout <= 1'b1;
                        done    <= 1'b1;
                        state   <= FINISH;
                    end
                end

                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                    read  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hdmi_qsys_sysid_checker.sv
// ---------------------------------------------------------------------------
// tb_hdmi_qsys_sysid_checker
// Directed bench for the sysid checker. A small sysid slave model returns
// id_resp at word 0 and ts_resp at word 1, with a programmable number of
// stall cycles per read or a stuck waitrequest. The DUT runs with
// TIMEOUT_CYCLES=4.
// ---------------------------------------------------------------------------
module tb_hdmi_qsys_sysid_checker;

    localparam logic [31:0] TS_GOOD = 32'd1539604058;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic        address;
    logic        read;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        busy;
    logic        done;
    logic        id_ok;
    logic        ts_ok;
    logic        timeout;
    logic [31:0] id_value;
    logic [31:0] ts_value;

    logic [31:0] id_resp;
    logic [31:0] ts_resp;
    logic        stuck;
    int          stall_cfg;
    int          stall_cnt = 0;

    int vectors     = 0;
    int miscompares = 0;

    int done_cnt  = 0;
    int addr1_cnt = 0;
    int read_cnt  = 0;
    int base;

    always #5 clock = ~clock;

    hdmi_qsys_sysid_checker #(
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .address     (address),
        .read        (read),
        .waitrequest (waitrequest),
        .readdata    (readdata),
        .busy        (busy),
        .done        (done),
        .id_ok       (id_ok),
        .ts_ok       (ts_ok),
        .timeout     (timeout),
        .id_value    (id_value),
        .ts_value    (ts_value)
    );

    // Sysid slave model
    assign readdata    = address ? ts_resp : id_resp;
    assign waitrequest = stuck || (read && (stall_cnt < stall_cfg));

    always_ff @(posedge clock) begin
        stall_cnt <= (read && waitrequest) ? stall_cnt + 1 : 0;
        if (done)            done_cnt  <= done_cnt + 1;
        if (read && address) addr1_cnt <= addr1_cnt + 1;
        if (read)            read_cnt  <= read_cnt + 1;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk1({tag, " read"},    read,    1'b0);
        chk1({tag, " address"}, address, 1'b0);
        chk1({tag, " busy"},    busy,    1'b0);
        chk1({tag, " done"},    done,    1'b0);
        chk1({tag, " id_ok"},   id_ok,   1'b0);
        chk1({tag, " ts_ok"},   ts_ok,   1'b0);
        chk1({tag, " timeout"}, timeout, 1'b0);
        chk({tag, " id_value"}, id_value, 32'd0);
        chk({tag, " ts_value"}, ts_value, 32'd0);
    endtask

    initial begin
        // Reset, with a start held high that must be ignored
        reset_n   = 1'b0;
        start     = 1'b1;
        stuck     = 1'b0;
        stall_cfg = 0;
        id_resp   = 32'd0;
        ts_resp   = TS_GOOD;
        repeat (3) tick();
        chk_reset_state("rst");
        start   = 1'b0;
        reset_n = 1'b1;

        // Idle after reset release
        base = done_cnt;
        repeat (20) tick();
`ifdef SYSID_CHECKER_AUTOSTART_EN
        chk("autostart done count", 32'(done_cnt - base), 32'd1);
        chk1("autostart id_ok", id_ok, 1'b1);
        chk1("autostart ts_ok", ts_ok, 1'b1);
`else
        chk("no autostart reads", 32'(read_cnt), 32'd0);
        chk1("no autostart busy", busy, 1'b0);
`endif

        // Basic check, no stalls, minimum latency
        start = 1'b1;
        tick();
        start = 1'b0;
        chk1("t1 N+1 read", read, 1'b1);
        chk1("t1 N+1 addr", address, 1'b0);
        chk1("t1 N+1 busy", busy, 1'b1);
        tick();
        chk1("t1 N+2 read", read, 1'b1);
        chk1("t1 N+2 addr", address, 1'b1);
        tick();
        chk1("t1 N+3 done", done, 1'b1);
        chk1("t1 N+3 read", read, 1'b0);
        chk1("t1 N+3 busy", busy, 1'b1);
        chk1("t1 id_ok", id_ok, 1'b1);
        chk1("t1 ts_ok", ts_ok, 1'b1);
        chk1("t1 timeout", timeout, 1'b0);
        chk("t1 ts_value", ts_value, TS_GOOD);
        chk("t1 id_value", id_value, 32'd0);
        tick();
        chk1("t1 N+4 done", done, 1'b0);
        chk1("t1 N+4 busy", busy, 1'b0);
        chk1("t1 flags hold", ts_ok, 1'b1);

        // Start held during the busy cycles must not retrigger
        base  = read_cnt;
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        tick();
        chk1("t2 done", done, 1'b1);
        tick();
        repeat (3) tick();
        chk("t2 read cycles", 32'(read_cnt - base), 32'd2);
        chk1("t2 idle read", read, 1'b0);

        // Timestamp mismatch
        ts_resp = TS_GOOD + 32'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk1("t3 done", done, 1'b1);
        chk1("t3 ts_ok", ts_ok, 1'b0);
        chk1("t3 id_ok", id_ok, 1'b1);
        chk1("t3 timeout", timeout, 1'b0);
        chk("t3 ts_value", ts_value, 32'd1539604059);
        tick();

        // Three stall cycles on each read
        ts_resp   = TS_GOOD;
        stall_cfg = 3;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk1("t4 id read", read, 1'b1);
            chk1("t4 id addr", address, 1'b0);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            chk1("t4 ts read", read, 1'b1);
            chk1("t4 ts addr", address, 1'b1);
            tick();
        end
        chk1("t4 N+9 done", done, 1'b1);
        chk1("t4 id_ok", id_ok, 1'b1);
        chk1("t4 ts_ok", ts_ok, 1'b1);
        chk1("t4 timeout", timeout, 1'b0);
        tick();
        stall_cfg = 0;

        // Id mismatch, leaves a distinctive id_value behind
        id_resp = 32'hDEAD_BEEF;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk1("t5 id_ok", id_ok, 1'b0);
        chk("t5 id_value", id_value, 32'hDEAD_BEEF);
        chk1("t5 ts_ok", ts_ok, 1'b1);
        tick();

        // Waitrequest stuck high: read abandoned after 4 stall cycles
        id_resp = 32'd0;
        stuck   = 1'b1;
        base    = addr1_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk1("t6 stall read", read, 1'b1);
            chk1("t6 stall addr", address, 1'b0);
            tick();
        end
        chk1("t6 read dropped", read, 1'b0);
        chk1("t6 done", done, 1'b1);
        chk1("t6 timeout", timeout, 1'b1);
        chk1("t6 id_ok", id_ok, 1'b0);
        chk1("t6 ts_ok", ts_ok, 1'b0);
        chk("t6 id_value kept", id_value, 32'hDEAD_BEEF);
        chk("t6 ts_value kept", ts_value, TS_GOOD);
        chk("t6 no addr1 read", 32'(addr1_cnt - base), 32'd0);
        tick();
        stuck = 1'b0;
        chk1("t6 done low", done, 1'b0);
        chk1("t6 busy low", busy, 1'b0);
        chk1("t6 timeout held", timeout, 1'b1);

        // Reset during RD_TS aborts with no done pulse
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk1("t7 in rd_ts", address, 1'b1);
        base    = done_cnt;
        reset_n = 1'b0;
        tick();
        chk_reset_state("t7 rst");
        reset_n = 1'b1;
        tick();
        tick();
        chk("t7 no done", 32'(done_cnt - base), 32'd0);
        chk1("t7 idle read", read, 1'b0);

        // Normal check after the aborted one
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk1("t8 done", done, 1'b1);
        chk1("t8 id_ok", id_ok, 1'b1);
        chk1("t8 ts_ok", ts_ok, 1'b1);
        chk("t8 ts_value", ts_value, TS_GOOD);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hdmi_qsys_sysid_checker.md
HDMI_QSYS_SYSID_CHECKER -- requirements
Module: hdmi_qsys_sysid_checker

Interface
REQ-001 SHALL have parameter EXPECTED_ID, default 32'd0, which is the value expected at sysid word address 0.
REQ-002 SHALL have parameter EXPECTED_TS, default 32'd1539604058, which is the value expected at sysid word address 1 (timestamp).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255 (range 1..65535), which is the maximum number of waitrequest-high cycles per read.
REQ-004 SHALL have port clock, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port start, input, 1 bit: a one-cycle pulse that launches a check.
REQ-007 SHALL have Avalon-MM master ports: address (output, 1), read (output, 1), waitrequest (input, 1), readdata (input, 32).
REQ-008 SHALL have status ports, all outputs: busy (1), done (1-cycle pulse), id_ok (1), ts_ok (1), timeout (1), id_value (32), ts_value (32).

Function
REQ-009 SHALL implement FSM states IDLE, RD_ID, RD_TS, FINISH.
REQ-010 IDLE: on start=1, go to RD_TS' predecessor RD_ID; clear id_ok, ts_ok and timeout the same cycle; start while busy SHALL be ignored.
REQ-011 RD_ID: read=1, address=0; on the first cycle with waitrequest=0, capture readdata into id_value, set id_ok=(readdata==EXPECTED_ID), and go to RD_TS.
REQ-012 RD_TS: read=1, address=1; on waitrequest=0, capture ts_value, set ts_ok=(readdata==EXPECTED_TS), and go to FINISH.
REQ-013 Read data SHALL be sampled in the cycle the transfer is accepted (read latency 0, no readdatavalid).
REQ-014 address and read SHALL be held stable while waitrequest=1.
REQ-015 Timeout counter: cleared on entry to each read state and incremented each cycle waitrequest=1; on reaching TIMEOUT_CYCLES, drop read, set timeout=1, leave the corresponding _ok=0 and _value unchanged, and go to FINISH.
REQ-016 FINISH: done=1 for exactly one cycle, then IDLE; result flags hold until the next start.
REQ-017 busy=1 in RD_ID, RD_TS and FINISH; read=0 in IDLE and FINISH.
REQ-018 Minimum latency with waitrequest=0: start at cycle N gives reads at N+1 and N+2 and done at N+3.
REQ-019 A waitrequest deassert in the same cycle the counter reaches TIMEOUT_CYCLES SHALL count as a completed read, not a timeout.

Reset
REQ-020 reset_n=0 at a clock edge SHALL force IDLE; read=0, address=0, busy=0, done=0, id_ok=0, ts_ok=0, timeout=0, id_value=0, ts_value=0, counter=0.
REQ-021 Reset mid-read SHALL abort immediately with no done pulse; a start coincident with reset SHALL be ignored.

Configuration
REQ-022 SHALL support macro SYSID_CHECKER_AUTOSTART_EN: when defined, the first cycle after reset_n goes high acts as an internal start pulse (once per reset); when undefined, checks run only on the start port.

Structure
REQ-023 Package hdmi_qsys_sysid_pkg SHALL hold the FSM state enum, the ADDR_ID=0/ADDR_TS=1 constants, and the default EXPECTED_ID/EXPECTED_TS constants.
REQ-024 The timeout counter SHALL be a sub-module, hdmi_qsys_sysid_timeout (clear, enable, limit input, expired output); everything else stays flat.

Verification
REQ-025 Against the sysid slave model with waitrequest tied 0, start pulse -> reads at addr 0 then 1, done at +3 cycles, id_ok=1, ts_ok=1, ts_value=1539604058.
REQ-026 With the timestamp returning 1539604059 -> ts_ok=0, id_ok=1, timeout=0, ts_value=1539604059.
REQ-027 With waitrequest high for 3 cycles on each read -> address and read stable during the stall, done at +9 cycles, both ok flags set.
REQ-028 With waitrequest stuck high and TIMEOUT_CYCLES=4 -> read drops after 4 stall cycles, timeout=1, id_ok=0, done pulses, and no address-1 read occurs.
REQ-029 With reset_n low during RD_TS -> next cycle all outputs are at reset values, no done pulse, and a subsequent start completes normally.
REQ-030 With SYSID_CHECKER_AUTOSTART_EN defined -> a check runs after reset with no start pulse; undefined -> no read occurs for 20 cycles.
